// File: rtl/decstage_pipe_if.sv
// Decode-stage handshake bundle: upstream instruction, writeback port and
// the registered ID/EX slot. "master" drives the stage, "slave" is the stage.
interface decstage_pipe_if #(
  parameter int DW    = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic          In_valid;
  logic          In_ready;
  logic [31:0]   Instr;
  logic          RF_B_sel;
  logic [1:0]    Imm_mode;
  logic          Dest_en;
  logic          Wb_en;
  logic [AW-1:0] Wb_addr;
  logic [DW-1:0] Wb_data;
  logic          Flush;
  logic          Out_valid;
  logic          Out_ready;
  logic [DW-1:0] Out_RF_A;
  logic [DW-1:0] Out_RF_B;
  logic [DW-1:0] Out_Immed;
  logic [AW-1:0] Out_Dest;
  logic          Out_Dest_en;

  modport master (
    output In_valid, Instr, RF_B_sel, Imm_mode, Dest_en,
           Wb_en, Wb_addr, Wb_data, Flush, Out_ready,
    input  In_ready, Out_valid, Out_RF_A, Out_RF_B, Out_Immed,
           Out_Dest, Out_Dest_en
  );

  modport slave (
    input  In_valid, Instr, RF_B_sel, Imm_mode, Dest_en,
           Wb_en, Wb_addr, Wb_data, Flush, Out_ready,
    output In_ready, Out_valid, Out_RF_A, Out_RF_B, Out_Immed,
           Out_Dest, Out_Dest_en
  );
endinterface

// File: rtl/decstage_pipe.sv
// Decode stage: register file with writeback bypass, immediate extension,
// RAW scoreboard and a single registered ID/EX slot with valid/ready.
module decstage_pipe #(
  parameter int DW    = 32,
  parameter int NREGS = 32
) (
  input  logic           Clk,
  input  logic           Reset,
  decstage_pipe_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

  slot_state_t      state_q, state_d;
  logic [DW-1:0]    rf [NREGS];
  logic [NREGS-1:0] pend, pend_d;
  logic [4:0]       rs_f, rd_f, rt_f;
  logic [AW-1:0]    rs, rd, rt, src_b;
  logic [15:0]      imm;
  logic [DW-1:0]    imm_sx, imm_ext, opnd_a, opnd_b;
  logic             haz_a, haz_b, out_valid, xfer, accept, in_ready;
  logic             unused_instr;

  // Register fields are 5 bits wide; only the low AW bits address the file.
  assign rs_f  = bus.Instr[25:21];
  assign rd_f  = bus.Instr[20:16];
  assign rt_f  = bus.Instr[15:11];
  assign rs    = rs_f[AW-1:0];
  assign rd    = rd_f[AW-1:0];
  assign rt    = rt_f[AW-1:0];
  assign imm   = bus.Instr[15:0];
  assign src_b = bus.RF_B_sel ? rd : rt;
  assign unused_instr = ^bus.Instr;

  assign xfer = out_valid & bus.Out_ready;

  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    if (rs != '0)
      haz_a = (pend[rs] && !(bus.Wb_en && bus.Wb_addr == rs)) ||
              (out_valid && bus.Out_Dest_en && bus.Out_Dest == rs && !xfer);
    if (src_b != '0)
      haz_b = (pend[src_b] && !(bus.Wb_en && bus.Wb_addr == src_b)) ||
              (out_valid && bus.Out_Dest_en && bus.Out_Dest == src_b && !xfer);
  end

  assign in_ready     = !bus.Flush && !haz_a && !haz_b && (!out_valid || bus.Out_ready);
  assign accept       = bus.In_valid & in_ready;
  assign bus.In_ready = in_ready;

  // Same-cycle writeback is forwarded so a released consumer sees the new value.
  always_comb begin
    opnd_a = '0;
    opnd_b = '0;
    if (rs != '0)
      opnd_a = (bus.Wb_en && bus.Wb_addr == rs) ? bus.Wb_data : rf[rs];
    if (src_b != '0)
      opnd_b = (bus.Wb_en && bus.Wb_addr == src_b) ? bus.Wb_data : rf[src_b];
  end

  always_comb begin
    imm_sx  = {{(DW-16){imm[15]}}, imm};
    imm_ext = '0;
    case (bus.Imm_mode)
      2'b00: imm_ext = imm_sx;
      2'b01: imm_ext = {{(DW-16){1'b0}}, imm};
      2'b10: imm_ext[31:16] = imm;
      2'b11: imm_ext = imm_sx << 2;
      default: imm_ext = '0;
    endcase
  end

  // Set after clear so a producer issuing in the writeback cycle stays pending.
  always_comb begin
    pend_d = pend;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (bus.Wb_en && bus.Wb_addr == AW'(i))
        pend_d[i] = 1'b0;
      if (xfer && bus.Out_Dest_en && bus.Out_Dest == AW'(i))
        pend_d[i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pend <= '0;
    else       pend <= pend_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else if (bus.Wb_en && bus.Wb_addr != '0) begin
      rf[bus.Wb_addr] <= bus.Wb_data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= SLOT_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL: begin
        if (accept)                        state_d = SLOT_FULL;
        else if (bus.Flush || bus.Out_ready) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    out_valid     = (state_q == SLOT_FULL);
    bus.Out_valid = out_valid;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.Out_RF_A    <= '0;
      bus.Out_RF_B    <= '0;
      bus.Out_Immed   <= '0;
      bus.Out_Dest    <= '0;
      bus.Out_Dest_en <= 1'b0;
    end else if (accept) begin
      bus.Out_RF_A    <= opnd_a;
      bus.Out_RF_B    <= opnd_b;
      bus.Out_Immed   <= imm_ext;
      bus.Out_Dest    <= rd;
      bus.Out_Dest_en <= bus.Dest_en;
    end
  end

endmodule

// File: tb/tb_decstage_pipe.sv
// Directed plus randomized bench for decstage_pipe against a behavioural model
// of registers, pending flags and the output slot.
module tb_decstage_pipe;
  localparam int DW    = 32;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decstage_pipe_if #(.DW(DW), .NREGS(NREGS)) bus ();
  decstage_pipe #(.DW(DW), .NREGS(NREGS)) dut (.Clk(clk), .Reset(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0]   mregs [NREGS];
  bit            mpend [NREGS];
  bit            mvalid;
  logic [31:0]   m_a, m_b, m_imm;
  logic [AW-1:0] m_dest;
  bit            m_den;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int rs, input int rd, input logic [15:0] low);
    return {6'd0, 5'(rs), 5'(rd), low};
  endfunction

  function automatic logic [AW-1:0] fld(input int lsb);
    int unsigned v;
    v = (32'(bus.Instr) >> lsb) & 31;
    return AW'(v % NREGS);
  endfunction

  function automatic logic [AW-1:0] src_a_m();
    return fld(21);
  endfunction

  function automatic logic [AW-1:0] src_b_m();
    return bus.RF_B_sel ? fld(16) : fld(11);
  endfunction

  // A source stalls while its producer is pending and not writing back now,
  // or while the producer still sits unissued in the output slot.
  function automatic bit m_haz(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return (mpend[a] && !(bus.Wb_en && bus.Wb_addr == a)) ||
           (mvalid && m_den && m_dest == a && !bus.Out_ready);
  endfunction

  function automatic bit m_ready();
    return !bus.Flush && !m_haz(src_a_m()) && !m_haz(src_b_m()) && (!mvalid || bus.Out_ready);
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return 32'd0;
    if (bus.Wb_en && bus.Wb_addr == a) return bus.Wb_data;
    return mregs[a];
  endfunction

  function automatic logic [31:0] m_immed();
    int s;
    int unsigned u;
    s = int'($signed(bus.Instr[15:0]));
    u = 32'(bus.Instr[15:0]);
    case (bus.Imm_mode)
      2'd0: return 32'(s);
      2'd1: return u;
      2'd2: return u * 65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mregs[i] = '0;
      mpend[i] = 1'b0;
    end
    mvalid = 1'b0; m_a = '0; m_b = '0; m_imm = '0; m_dest = '0; m_den = 1'b0;
  endtask

  task automatic idle();
    bus.In_valid = 1'b0; bus.Instr = '0; bus.RF_B_sel = 1'b0; bus.Imm_mode = 2'd0;
    bus.Dest_en = 1'b0; bus.Wb_en = 1'b0; bus.Wb_addr = '0; bus.Wb_data = '0;
    bus.Flush = 1'b0; bus.Out_ready = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.Out_valid), 32'(mvalid));
    chk({tag, ".rf_a"},      bus.Out_RF_A, m_a);
    chk({tag, ".rf_b"},      bus.Out_RF_B, m_b);
    chk({tag, ".immed"},     bus.Out_Immed, m_imm);
    chk({tag, ".dest"},      32'(bus.Out_Dest), 32'(m_dest));
    chk({tag, ".dest_en"},   32'(bus.Out_Dest_en), 32'(m_den));
  endtask

  task automatic cycle(input string tag);
    bit exp_ready, acc, xfer;
    logic [31:0] na, nb, ni;
    @(negedge clk);
    exp_ready = m_ready();
    chk({tag, ".in_ready"}, 32'(bus.In_ready), 32'(exp_ready));
    @(posedge clk);
    acc  = bus.In_valid && exp_ready;
    xfer = mvalid && bus.Out_ready;
    na = m_read(src_a_m());
    nb = m_read(src_b_m());
    ni = m_immed();
    if (bus.Wb_en) mpend[bus.Wb_addr] = 1'b0;
    if (xfer && m_den && m_dest != 0) mpend[m_dest] = 1'b1;
    if (bus.Wb_en && bus.Wb_addr != 0) mregs[bus.Wb_addr] = bus.Wb_data;
    if (acc) begin
      mvalid = 1'b1; m_a = na; m_b = nb; m_imm = ni; m_dest = fld(16); m_den = bus.Dest_en;
    end else if (bus.Flush || xfer) begin
      mvalid = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  // Reset is raised between clock edges and checked before any edge follows.
  task automatic async_reset(input string tag);
    idle();
    #3 rst = 1'b1;
    #1;
    chk({tag, ".valid_now"}, 32'(bus.Out_valid), 32'd0);
    chk({tag, ".rf_a_now"},  bus.Out_RF_A, 32'd0);
    chk({tag, ".immed_now"}, bus.Out_Immed, 32'd0);
    model_reset();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs({tag, ".after"});
  endtask

  logic [31:0] imm_tab [4];
  int cand[$];

  initial begin
    imm_tab[0] = 32'hFFFF_FFF0; imm_tab[1] = 32'h0000_FFF0;
    imm_tab[2] = 32'hFFF0_0000; imm_tab[3] = 32'hFFFF_FFC0;
    model_reset();
    idle();
    async_reset("reset");
    cycle("idle_ready");

    bus.Wb_en = 1'b1; bus.Wb_addr = 4'd1; bus.Wb_data = 32'd7; cycle("wb_r1");
    bus.Wb_addr = 4'd2; bus.Wb_data = 32'd5; cycle("wb_r2");
    bus.Wb_en = 1'b0;

    bus.In_valid = 1'b1; bus.Instr = mk(1, 0, 16'(2 << 11)); cycle("read_r1_r2");
    chk("basic.a", bus.Out_RF_A, 32'd7);
    chk("basic.b", bus.Out_RF_B, 32'd5);

    for (int m = 0; m < 4; m++) begin
      bus.Instr = mk(0, 0, 16'hFFF0); bus.Imm_mode = 2'(m);
      cycle("imm");
      chk("imm_mode", bus.Out_Immed, imm_tab[m]);
    end
    bus.Imm_mode = 2'd0;

    bus.Instr = mk(0, 3, 16'h0); bus.Dest_en = 1'b1; cycle("issue_r3");
    bus.In_valid = 1'b0; bus.Dest_en = 1'b0; cycle("xfer_r3");
    bus.In_valid = 1'b1; bus.Instr = mk(3, 0, 16'h0);
    cycle("stall_r3_0");
    cycle("stall_r3_1");
    bus.Wb_en = 1'b1; bus.Wb_addr = 4'd3; bus.Wb_data = 32'd12; cycle("wb_release_r3");
    chk("bypass.a", bus.Out_RF_A, 32'd12);
    bus.Wb_en = 1'b0;

    bus.Out_ready = 1'b0; bus.Instr = mk(1, 0, 16'(2 << 11));
    for (int k = 0; k < 3; k++) cycle("backpressure");
    bus.Out_ready = 1'b1; cycle("release");
    chk("release.a", bus.Out_RF_A, 32'd7);

    bus.Instr = mk(0, 5, 16'h0); bus.Dest_en = 1'b1; cycle("issue_r5");
    bus.In_valid = 1'b0; bus.Dest_en = 1'b0; bus.Out_ready = 1'b0; bus.Flush = 1'b1;
    cycle("flush");
    chk("flush.valid", 32'(bus.Out_valid), 32'd0);
    bus.Flush = 1'b0; bus.Out_ready = 1'b1;
    bus.In_valid = 1'b1; bus.Instr = mk(5, 0, 16'h0); cycle("read_r5");
    bus.Instr = mk(0, 0, 16'h0); bus.Wb_en = 1'b1; bus.Wb_addr = '0; bus.Wb_data = 32'hDEAD;
    cycle("wb_r0_same");
    bus.Wb_en = 1'b0; cycle("read_r0");
    chk("r0.a", bus.Out_RF_A, 32'd0);

    bus.Instr = mk(0, 3, 16'h0); bus.Dest_en = 1'b1; cycle("issue_r3b");
    bus.Instr = mk(3, 0, 16'h0); bus.Dest_en = 1'b0; cycle("xfer_r3b");
    bus.Out_ready = 1'b0; cycle("hold_r3b");
    async_reset("midreset");
    bus.In_valid = 1'b1; bus.Instr = mk(3, 0, 16'h0); cycle("post_reset_r3");
    chk("post_reset.in_valid", 32'(bus.Out_valid), 32'd1);

    for (int n = 0; n < 400; n++) begin
      bus.In_valid  = ($urandom_range(0, 3) != 0);
      bus.Instr     = $urandom();
      bus.RF_B_sel  = 1'($urandom_range(0, 1));
      bus.Imm_mode  = 2'($urandom_range(0, 3));
      bus.Dest_en   = 1'($urandom_range(0, 1));
      bus.Wb_en     = ($urandom_range(0, 2) != 0);
      bus.Wb_addr   = AW'($urandom_range(0, NREGS - 1));
      cand.delete();
      for (int i = 1; i < NREGS; i++) if (mpend[i]) cand.push_back(i);
      if (cand.size() != 0 && $urandom_range(0, 1) == 1)
        bus.Wb_addr = AW'(cand[$urandom_range(0, cand.size() - 1)]);
      bus.Wb_data   = $urandom();
      bus.Flush     = ($urandom_range(0, 19) == 0);
      bus.Out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decstage_pipe.md
Name: decstage_pipe

Overview:
- Parametrised successor to the single-cycle decode stage: register file, immediate extension, and a registered ID/EX output slot with valid/ready handshake.
- Adds a pending-write scoreboard that stalls read-after-write hazards, a same-cycle writeback bypass, and a flush.
- Sits between fetch and execute. Writeback arrives on a dedicated port, not through Instr.

Parameters:
- DW, 32, datapath width; legal values ≥32.
- NREGS, 32, register count; power of 2, 2..32. AW = log2(NREGS) is a localparam.
- Each 5-bit register field of Instr uses its low AW bits.

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
In_valid  in  1  upstream instruction valid
In_ready  out  1  stage accepts the instruction this cycle
Instr  in  32  instruction: rs=[25:21], rd=[20:16], rt=[15:11], imm=[15:0]
RF_B_sel  in  1  0: B reads rt; 1: B reads rd
Imm_mode  in  2  00 sign-ext, 01 zero-ext, 10 imm<<16, 11 sign-ext<<2
Dest_en  in  1  instruction will write rd
Wb_en  in  1  writeback strobe
Wb_addr  in  AW  writeback register
Wb_data  in  DW  writeback data
Flush  in  1  kill the output slot
Out_valid  out  1  output slot valid
Out_ready  in  1  downstream accepts the slot
Out_RF_A  out  DW  operand A
Out_RF_B  out  DW  operand B
Out_Immed  out  DW  extended immediate
Out_Dest  out  AW  destination register (rd)
Out_Dest_en  out  1  destination write flag

Behaviour:
Reset:
- Reset high clears all registers immediately, independent of Clk: every rf entry, the scoreboard, Out_valid, Out_RF_A/B, Out_Immed, Out_Dest and Out_Dest_en go to 0.
- In_ready evaluates to 1 while no hazard is present.
- Reset mid-transfer discards both the output slot and all pending bits.

Register file:
- r0 reads 0 and ignores writes.
- Writes occur on the Clk edge when Wb_en=1 and Wb_addr≠0.

Bypass:
- A read of register x in the same cycle as Wb_en with Wb_addr=x (x≠0) returns Wb_data.

Scoreboard:
- pend[NREGS-1:1], one bit per register.
- Set pend[Out_Dest] on an output transfer (Out_valid & Out_ready & Out_Dest_en & Out_Dest≠0).
- Clear pend[Wb_addr] on Wb_en.
- If set and clear hit the same register in the same cycle, set wins.

Hazard (combinational):
- A source is rs, plus rt or rd as selected by RF_B_sel.
- A source ≠0 is a hazard if either:
  - its pend bit is 1 and (Wb_en & Wb_addr=src) is false, or
  - Out_valid & Out_Dest_en & Out_Dest=src and (Out_valid & Out_ready) is false. An in-flight producer that has not yet issued always stalls.
- In_ready = !hazard & (!Out_valid | Out_ready).

Accept and latency:
- Accept = In_valid & In_ready.
- On accept the operands, immediate, Dest and Dest_en are captured into the slot and Out_valid=1 the next cycle. Latency is 1 cycle.
- Sustained throughput is 1 instruction/cycle when there are no hazards.

Output slot:
- While Out_valid & !Out_ready, all Out_* outputs hold stable.
- Output transfer with no accept: Out_valid→0.

Flush:
- Out_valid→0 on the next edge and the incoming instruction is not accepted.
- In_ready=0 during Flush.
- The scoreboard is unchanged and a transfer in the same cycle still sets pend. Issued instructions always write back.

Immediate:
- Sign/zero extension is to DW bits.
- Mode 10 places imm at bits [31:16] with [15:0]=0, zero-extended above bit 31.
- Mode 11 sign-extends and then shifts left by 2, truncated to DW.

Test Plan:
- Reset, then Wb_en r1=7, r2=5. Accept Instr rs=1, rt=2, RF_B_sel=0 → next cycle Out_valid=1, Out_RF_A=7, Out_RF_B=5.
- Imm=0xFFF0 in modes 00/01/10/11 → Out_Immed = 0xFFFFFFF0 / 0x0000FFF0 / 0xFFF00000 / 0xFFFFFFC0.
- Issue rd=3 with Dest_en=1. Next instruction reads r3 → In_ready=0 until Wb_en r3=12. In that Wb cycle In_ready=1 and captured Out_RF_A=12.
- Out_ready=0 for 3 cycles with a valid slot → outputs stable, In_ready=0. Out_ready=1 → transfer, and the new instruction is accepted in the same cycle.
- Flush with slot valid → Out_valid=0 next cycle, pend unchanged. Write to r0 followed by a read of r0 → 0, no stall.
- Assert Reset asynchronously mid-cycle with pend[3]=1 → Out_valid=0 immediately, pend cleared, a read of r3 does not stall.
